// File: rtl/core_seq_if.sv
// Handshake and instruction bus between the core sequencer and its controller.
interface core_seq_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [19:0] inst;

  modport master (output start, input busy, input done, input inst);
  modport slave  (input start, output busy, output done, output inst);
endinterface

// File: rtl/core_seq.sv
// Core instruction sequencer: K load, execute, OFIFO drain, optional normalisation.
// Define SEQ_NORM_EN to add the ACC/DIV/WB normalisation phases after OFIFO.
module core_seq #(
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap         = 10
) (
  input logic        clk,
  input logic        reset,
  core_seq_if.slave  bus
);

  localparam int unsigned CW = 16;

  localparam int unsigned B_WR2PMEM = 19;
  localparam int unsigned B_DIV     = 18;
  localparam int unsigned B_ACC     = 17;
  localparam int unsigned B_OFIFO   = 16;
  localparam int unsigned B_EXEC    = 7;
  localparam int unsigned B_LOAD    = 6;
  localparam int unsigned B_QRD     = 5;
  localparam int unsigned B_KRD     = 3;
  localparam int unsigned B_PRD     = 1;
  localparam int unsigned B_PWR     = 0;

  typedef enum logic [3:0] {
    IDLE, KLOAD, KEND, GAP1, EXEC, GAP2, OFIFO, ACC, DIV, WB, DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            at_end;

  function automatic logic [CW-1:0] last_of(input state_t s);
    case (s)
      KLOAD:       return CW'(col);
      GAP1, GAP2:  return CW'(gap - 1);
      EXEC, OFIFO: return CW'(total_cycle - 1);
      ACC, WB:     return CW'(2 * total_cycle - 1);
      default:     return '0;
    endcase
  endfunction

  function automatic logic [19:0] inst_of(input state_t s, input logic [CW-1:0] n);
    logic [19:0]   i;
    logic [CW-1:0] nm1;
    i   = '0;
    nm1 = n - 1'b1;
    case (s)
      KLOAD: begin
        i[B_LOAD] = 1'b1;
        if (n >= CW'(1)) i[B_KRD] = 1'b1;
        if (n >= CW'(2)) i[15:12] = nm1[3:0];
      end
      KEND: i[B_LOAD] = 1'b1;
      EXEC: begin
        i[B_EXEC] = 1'b1;
        i[B_QRD]  = 1'b1;
        i[15:12]  = n[3:0];
      end
      OFIFO: begin
        i[B_OFIFO] = 1'b1;
        i[B_PWR]   = 1'b1;
        i[11:8]    = n[3:0];
      end
`ifdef SEQ_NORM_EN
      // ACC and WB walk each pmem row twice, so the row is n/2
      ACC: begin
        i[B_PRD] = 1'b1;
        i[B_ACC] = 1'b1;
        i[11:8]  = n[4:1];
      end
      DIV: i[B_DIV] = 1'b1;
      WB: begin
        i[B_PRD] = 1'b1;
        i[11:8]  = n[4:1];
        if (!n[0]) begin
          i[B_DIV]     = 1'b1;
          i[B_WR2PMEM] = 1'b1;
          i[B_PWR]     = 1'b1;
        end
      end
`endif
      default: i = '0;
    endcase
    return i;
  endfunction

  always_comb begin
    state_n = state;
    at_end  = (cnt == last_of(state));
    case (state)
      IDLE:  if (bus.start) state_n = KLOAD;
      KLOAD: if (at_end) state_n = KEND;
      KEND:  state_n = GAP1;
      GAP1:  if (at_end) state_n = EXEC;
      EXEC:  if (at_end) state_n = GAP2;
      GAP2:  if (at_end) state_n = OFIFO;
`ifdef SEQ_NORM_EN
      OFIFO: if (at_end) state_n = ACC;
      ACC:   if (at_end) state_n = DIV;
      DIV:   state_n = WB;
      WB:    if (at_end) state_n = DONE;
`else
      OFIFO: if (at_end) state_n = DONE;
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    cnt_n = (state_n != state || state == IDLE || state == DONE) ? '0 : cnt + 1'b1;
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.inst <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bus.inst <= inst_of(state_n, cnt_n);
      bus.busy <= (state_n != IDLE) && (state_n != DONE);
      bus.done <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq; honours SEQ_NORM_EN for expected lengths.
module tb_core_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_seq_if bus ();

  core_seq #(.col(8), .total_cycle(8), .gap(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef SEQ_NORM_EN
  localparam int EXP_BUSY = 79;
`else
  localparam int EXP_BUSY = 46;
`endif

  int errors = 0;
  int checks = 0;
  logic [19:0] rec [0:299];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] exp_inst(input int k);
    logic [19:0] e;
`ifdef SEQ_NORM_EN
    int m;
`endif
    e = '0;
    if (k <= 8) begin
      e[6] = 1'b1;
      if (k >= 1) e[3] = 1'b1;
      if (k >= 2) e[15:12] = 4'(k - 1);
    end else if (k == 9) e[6] = 1'b1;
    else if (k >= 20 && k < 28) begin
      e[7] = 1'b1; e[5] = 1'b1; e[15:12] = 4'(k - 20);
    end else if (k >= 38 && k < 46) begin
      e[16] = 1'b1; e[0] = 1'b1; e[11:8] = 4'(k - 38);
    end
`ifdef SEQ_NORM_EN
    else if (k >= 46 && k < 62) begin
      e[17] = 1'b1; e[1] = 1'b1; e[11:8] = 4'((k - 46) / 2);
    end else if (k == 62) e[18] = 1'b1;
    else if (k >= 63 && k < 79) begin
      m = k - 63;
      e[1] = 1'b1;
      e[11:8] = 4'(m / 2);
      if (m % 2 == 0) begin
        e[19] = 1'b1; e[18] = 1'b1; e[0] = 1'b1;
      end
    end
`endif
    return e;
  endfunction

  task automatic capture(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      rec[n] = bus.inst;
      n++;
      step;
    end
  endtask

  task automatic start_pulse;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b1;
    repeat (3) step;
    checks++;
    if (bus.inst !== 20'h0) begin errors++; $display("FAIL reset_inst: got %h expected %h", bus.inst, 20'h0); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    reset = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      checks++;
      if ({bus.inst, bus.busy, bus.done} !== 22'h0) begin
        errors++;
        $display("FAIL idle_quiet[%0d]: got inst=%h busy=%b done=%b expected all 0", i, bus.inst, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_full_run(input int tag);
    int n;
    int loads;
    logic [2:0] norm_or;
    start_pulse;
    capture(n);
    checks++;
    if (n !== EXP_BUSY) begin errors++; $display("FAIL busy_len run%0d: got %0d expected %0d", tag, n, EXP_BUSY); end
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL done_pulse run%0d: got %b expected 1", tag, bus.done); end
    for (int k = 0; k < EXP_BUSY; k++) begin
      checks++;
      if (rec[k] !== exp_inst(k)) begin
        errors++;
        $display("FAIL inst run%0d cyc%0d: got %h expected %h", tag, k, rec[k], exp_inst(k));
      end
    end
    checks++;
    if (rec[1] !== 20'h00048) begin errors++; $display("FAIL kload1: got %h expected 00048", rec[1]); end
    checks++;
    if (rec[9] !== 20'h00040) begin errors++; $display("FAIL kend: got %h expected 00040", rec[9]); end
    checks++;
    if (rec[27] !== 20'h070A0) begin errors++; $display("FAIL exec_last: got %h expected 070a0", rec[27]); end
    checks++;
    if (rec[45] !== 20'h10701) begin errors++; $display("FAIL ofifo_last: got %h expected 10701", rec[45]); end
    loads = 0;
    norm_or = '0;
    for (int k = 0; k < EXP_BUSY; k++) begin
      if (rec[k][6]) loads++;
      norm_or = norm_or | rec[k][19:17];
    end
    checks++;
    if (loads !== 10) begin errors++; $display("FAIL load_count: got %0d expected 10", loads); end
`ifdef SEQ_NORM_EN
    begin
      int wrs;
      wrs = 0;
      for (int k = 63; k < 79; k++) if (rec[k][0]) wrs++;
      checks++;
      if (wrs !== 8) begin errors++; $display("FAIL wb_wr_count: got %0d expected 8", wrs); end
    end
    checks++;
    if (rec[47] !== 20'h20002) begin errors++; $display("FAIL acc_1: got %h expected 20002", rec[47]); end
    checks++;
    if (rec[63] !== 20'hC0003) begin errors++; $display("FAIL wb_0: got %h expected c0003", rec[63]); end
    checks++;
    if (rec[78] !== 20'h00702) begin errors++; $display("FAIL wb_last: got %h expected 00702", rec[78]); end
`else
    checks++;
    if (norm_or !== 3'b000) begin errors++; $display("FAIL norm_bits: got %b expected 000", norm_or); end
`endif
    step;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL post_done run%0d: got busy=%b done=%b expected 0 0", tag, bus.busy, bus.done);
    end
  endtask

  task automatic test_abort;
    logic seen_done;
    start_pulse;
    repeat (23) step;
    checks++;
    if (bus.inst !== 20'h030A0) begin errors++; $display("FAIL exec3: got %h expected 030a0", bus.inst); end
    reset = 1'b1;
    step;
    reset = 1'b0;
    checks++;
    if (bus.inst !== 20'h0) begin errors++; $display("FAIL abort_inst: got %h expected 00000", bus.inst); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    seen_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_quiet: got activity=%b expected 0", seen_done); end
    test_full_run(2);
  endtask

  task automatic test_back_to_back;
    int n;
    bus.start = 1'b1;
    step;
    for (int s = 0; s < 2; s++) begin
      capture(n);
      checks++;
      if (n !== EXP_BUSY) begin errors++; $display("FAIL b2b_len%0d: got %0d expected %0d", s, n, EXP_BUSY); end
      checks++;
      if ({bus.busy, bus.done} !== 2'b01) begin
        errors++;
        $display("FAIL b2b_done%0d: got busy=%b done=%b expected 0 1", s, bus.busy, bus.done);
      end
      step;
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        errors++;
        $display("FAIL b2b_idle%0d: got busy=%b done=%b expected 0 0", s, bus.busy, bus.done);
      end
      if (s == 1) bus.start = 1'b0;
      step;
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: got busy=%b expected 0", bus.busy); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    test_reset;
    test_full_run(1);
    test_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter col, default 8: number of K vectors to load (dot-product columns).
REQ-002 Parameter total_cycle, default 8: number of Q vectors executed and psum rows produced.
REQ-003 Parameter gap, default 10: idle cycles inserted after K load and after execute; legal range 1..255.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  one-cycle request to run the full sequence.
REQ-007 Port busy  output  1  high while a sequence is in progress.
REQ-008 Port done  output  1  one-cycle pulse when a sequence completes.
REQ-009 Port inst  output  20  core instruction word; registered.
- Bit 19 sfp_wr2pmem, 18 sfp_div, 17 sfp_acc, 16 ofifo_rd.
- Bits 15:12 qkmem_add, 11:8 pmem_add.
- Bit 7 execute, 6 load, 5 qmem_rd, 4 qmem_wr, 3 kmem_rd, 2 kmem_wr, 1 pmem_rd, 0 pmem_wr.

Function
REQ-010 The FSM SHALL have states IDLE, KLOAD, KEND, GAP1, EXEC, GAP2, OFIFO, ACC, DIV, WB, DONE.
REQ-011 In IDLE, start=1 SHALL move the FSM to KLOAD at the next edge; start in any other state SHALL be ignored.
REQ-012 Each state below SHALL last the stated number of cycles; every inst bit not listed SHALL be 0.
- KLOAD, col+1 cycles, phase index n=0..col: load=1; kmem_rd=1 for n>=1; qkmem_add=n-1 for n>=2, else 0.
- KEND, 1 cycle: load=1, kmem_rd=0, qkmem_add=0.
- GAP1 and GAP2, gap cycles each: inst=0.
- EXEC, total_cycle cycles, index n: execute=1, qmem_rd=1, qkmem_add=n.
- OFIFO, total_cycle cycles: ofifo_rd=1, pmem_wr=1, pmem_add=n.
- ACC, 2*total_cycle cycles: pmem_rd=1, sfp_acc=1, pmem_add=n/2 (each address held for 2 cycles).
- DIV, 1 cycle: sfp_div=1.
- WB, 2*total_cycle cycles, row r=n/2. Even n: sfp_div=1, sfp_wr2pmem=1, pmem_wr=1, pmem_rd=1, pmem_add=r. Odd n: pmem_rd=1, pmem_add=r.
- DONE, 1 cycle: inst=0, done=1; then the FSM returns to IDLE.
REQ-013 Address fields SHALL be 4 bits wide; values at or above 16 SHALL truncate modulo 16.
REQ-014 The phase counter SHALL reset to 0 on every state entry; states SHALL advance when counter = length-1.
REQ-015 busy SHALL be 1 in every state except IDLE and DONE; done SHALL be 1 only in DONE.
REQ-016 qmem_wr and kmem_wr SHALL always be 0; Q and K memories are filled externally before start.
REQ-017 With defaults and SEQ_NORM_EN defined, busy SHALL stay high for 79 cycles, and done SHALL rise on the edge immediately following the last busy cycle.
REQ-018 A start coincident with DONE SHALL be ignored; a start in the IDLE cycle after DONE SHALL be accepted.

Reset
REQ-019 reset=1 at a clock edge SHALL force IDLE, counter=0, inst=0, busy=0, done=0.
REQ-020 Reset SHALL take priority over start and abort any in-progress sequence within one cycle; no done pulse SHALL follow an aborted sequence.

Configuration
REQ-021 With SEQ_NORM_EN defined, the FSM SHALL run ACC, DIV and WB after OFIFO, then DONE.
REQ-022 Without SEQ_NORM_EN, the FSM SHALL go OFIFO->DONE, and inst bits 19:17 SHALL be constant 0.
REQ-023 Without SEQ_NORM_EN, defaults SHALL give 46 busy cycles.

Verification
REQ-024 Reset held 3 cycles, then released with start=0 -> inst=0, busy=0, done=0 indefinitely.
REQ-025 Defaults with SEQ_NORM_EN, start pulse -> load=1 for 10 cycles; kmem_rd=1 on KLOAD cycles 1..8 with qkmem_add 0,0..7; then 10 zero cycles; then execute with qkmem_add 0..7; then done after 79 busy cycles.
REQ-026 Same run -> ACC shows pmem_add 0,0,1,1..7,7; WB shows pmem_wr=1 exactly on 8 cycles, at pmem_add 0..7.
REQ-027 Reset asserted during EXEC cycle 3 -> next cycle inst=0 and busy=0; no done pulse; a new start then yields a full 79-cycle sequence.
REQ-028 start held high for 200 cycles -> back-to-back sequences, each separated by one DONE and one IDLE cycle; busy-high starts are ignored.
REQ-029 Build without SEQ_NORM_EN -> done after 46 busy cycles; bits 19:17 never asserted.
